// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry plus the memory-port arbiter types.
package cpu_pkg;

    localparam int MEM_ADDR_SIZE = 16;
    localparam int BYTE          = 8;
    localparam int ARB_NUM_REQ   = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        ARB_FETCH = 2'd0,
        ARB_LSU   = 2'd1,
        ARB_DMA   = 2'd2
    } arb_req_id_t;

    // Convert a one-hot winner vector into a requester ID (fetch when empty).
    function automatic arb_req_id_t arb_onehot_to_id(input logic [ARB_NUM_REQ-1:0] oh);
        if (oh[ARB_DMA])
            return ARB_DMA;
        else if (oh[ARB_LSU])
            return ARB_LSU;
        else
            return ARB_FETCH;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection: DMA first, then fetch/LSU round-robin,
// with fetch/LSU masked while a DMA burst holds the lock.
module arb_priority_pick
    import cpu_pkg::*;
(
    input  logic [ARB_NUM_REQ-1:0] req_i,
    input  logic                   last_lsu_i,
    input  logic                   lock_i,
    output logic [ARB_NUM_REQ-1:0] win_o
);

    // Priority resolution; a tie between fetch and LSU goes to whoever did not win last.
    always_comb begin
        win_o = '0;
        if (req_i[ARB_DMA]) begin
            win_o[ARB_DMA] = 1'b1;
        end else if (!lock_i) begin
            if (req_i[ARB_FETCH] && req_i[ARB_LSU]) begin
                if (last_lsu_i)
                    win_o[ARB_FETCH] = 1'b1;
                else
                    win_o[ARB_LSU] = 1'b1;
            end else if (req_i[ARB_FETCH]) begin
                win_o[ARB_FETCH] = 1'b1;
            end else if (req_i[ARB_LSU]) begin
                win_o[ARB_LSU] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch, LSU and DMA, one transaction
// at a time, with a request/ready issue phase and a valid-strobed response.
module mem_port_arbiter
    import cpu_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [ARB_NUM_REQ-1:0]   req_i,
    output logic [ARB_NUM_REQ-1:0]   gnt_o,
    input  logic [MEM_ADDR_SIZE-1:0] fetch_addr_i,
    input  logic [MEM_ADDR_SIZE-1:0] lsu_addr_i,
    input  logic [MEM_ADDR_SIZE-1:0] dma_addr_i,
    input  logic                     lsu_we_i,
    input  logic                     dma_we_i,
    input  logic [BYTE-1:0]          lsu_wdata_i,
    input  logic [BYTE-1:0]          dma_wdata_i,
    input  logic                     dma_lock_i,
    output logic [ARB_NUM_REQ-1:0]   done_o,
    output logic [BYTE-1:0]          rdata_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    input  logic                     mem_ready_i,
    output logic                     mem_we_o,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    output logic [BYTE-1:0]          mem_wdata_o,
    input  logic                     mem_valid_i,
    input  logic [BYTE-1:0]          mem_rdata_i
);

    arb_state_t               state_q;
    arb_req_id_t              owner_q;
    logic                     last_lsu_q;
    logic                     busy_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic                     lat_we_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [BYTE-1:0]          wdata_q;
    logic [BYTE-1:0]          rdata_q;
    logic [ARB_NUM_REQ-1:0]   done_q;

    logic [ARB_NUM_REQ-1:0]   win;
    logic                     lock_qual;
    arb_req_id_t              win_id;
    logic [MEM_ADDR_SIZE-1:0] addr_d;
    logic [BYTE-1:0]          wdata_d;
    logic                     we_d;

    // The lock only binds while the most recent owner was the DMA engine.
    assign lock_qual = dma_lock_i && (owner_q == ARB_DMA);

    arb_priority_pick u_pick (
        .req_i      (req_i),
        .last_lsu_i (last_lsu_q),
        .lock_i     (lock_qual),
        .win_o      (win)
    );

    assign win_id = arb_onehot_to_id(win);

    // Select the winning requester's transaction fields for latching.
    always_comb begin
        addr_d  = fetch_addr_i;
        wdata_d = '0;
        we_d    = 1'b0;
        case (win_id)
            ARB_LSU: begin
                addr_d  = lsu_addr_i;
                wdata_d = lsu_wdata_i;
                we_d    = lsu_we_i;
            end
            ARB_DMA: begin
                addr_d  = dma_addr_i;
                wdata_d = dma_wdata_i;
                we_d    = dma_we_i;
            end
            default: ;
        endcase
    end

    // Grant is combinational and only offered in IDLE; it is forced low while reset is held.
    assign gnt_o = (rstn_i && (state_q == ARB_IDLE)) ? win : '0;

    // Arbiter FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= ARB_FETCH;
            last_lsu_q <= 1'b1;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            lat_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (|win) begin
                        state_q   <= ARB_ISSUE;
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= we_d;
                        lat_we_q  <= we_d;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                        owner_q   <= win_id;
                        // DMA wins do not disturb the fetch/LSU rotation.
                        if (win_id != ARB_DMA)
                            last_lsu_q <= (win_id == ARB_LSU);
                    end
                end
                ARB_ISSUE: begin
                    if (mem_ready_i) begin
                        state_q   <= ARB_WAIT;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (mem_valid_i) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= ARB_NUM_REQ'(1) << owner_q;
                        if (!lat_we_q)
                            rdata_q <= mem_rdata_i;
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a bench-driven memory.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rstn_i;
    logic [2:0]               req_i;
    logic [2:0]               gnt_o;
    logic [15:0]              fetch_addr_i, lsu_addr_i, dma_addr_i;
    logic                     lsu_we_i, dma_we_i;
    logic [7:0]               lsu_wdata_i, dma_wdata_i;
    logic                     dma_lock_i;
    logic [2:0]               done_o;
    logic [7:0]               rdata_o;
    logic                     busy_o;
    logic                     mem_req_o;
    logic                     mem_ready_i;
    logic                     mem_we_o;
    logic [15:0]              mem_addr_o;
    logic [7:0]               mem_wdata_o;
    logic                     mem_valid_i;
    logic [7:0]               mem_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .fetch_addr_i (fetch_addr_i),
        .lsu_addr_i   (lsu_addr_i),
        .dma_addr_i   (dma_addr_i),
        .lsu_we_i     (lsu_we_i),
        .dma_we_i     (dma_we_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .dma_wdata_i  (dma_wdata_i),
        .dma_lock_i   (dma_lock_i),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .mem_req_o    (mem_req_o),
        .mem_ready_i  (mem_ready_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [2:0]  req;
        logic        lock;
        logic        lsu_we;
        logic        dma_we;
        logic [15:0] faddr;
        logic [15:0] laddr;
        logic [15:0] daddr;
        logic [7:0]  lwdata;
        logic [7:0]  dwdata;
        int          rdy_wait;
        logic [7:0]  mrdata;
        logic [2:0]  exp_gnt;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wdata;
        logic [2:0]  exp_done;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[8];
    vec_t v_unlock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one transaction starting in an IDLE cycle; ends in the done cycle.
    task automatic do_txn(input vec_t v);
        req_i        = v.req;
        dma_lock_i   = v.lock;
        lsu_we_i     = v.lsu_we;
        dma_we_i     = v.dma_we;
        fetch_addr_i = v.faddr;
        lsu_addr_i   = v.laddr;
        dma_addr_i   = v.daddr;
        lsu_wdata_i  = v.lwdata;
        dma_wdata_i  = v.dwdata;
        #1;
        chk({v.name, "_gnt"}, 32'(gnt_o), 32'(v.exp_gnt));
        tick();
        req_i = '0;
        for (int w = 0; w <= v.rdy_wait; w++) begin
            mem_ready_i = (w == v.rdy_wait);
            #1;
            chk({v.name, "_issue_req_busy"}, 32'({mem_req_o, busy_o}), 32'b11);
            chk({v.name, "_addr"}, 32'(mem_addr_o), 32'(v.exp_addr));
            chk({v.name, "_we"}, 32'(mem_we_o), 32'(v.exp_we));
            if (v.exp_we)
                chk({v.name, "_wdata"}, 32'(mem_wdata_o), 32'(v.exp_wdata));
            tick();
        end
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_rdata_i = v.mrdata;
        #1;
        chk({v.name, "_wait_req_we"}, 32'({mem_req_o, mem_we_o}), 32'b00);
        tick();
        mem_valid_i = 1'b0;
        chk({v.name, "_done"}, 32'(done_o), 32'(v.exp_done));
        chk({v.name, "_rdata"}, 32'(rdata_o), 32'(v.exp_rdata));
        chk({v.name, "_idle"}, 32'(busy_o), 32'b0);
    endtask

    initial begin
        //           name   req    lk  lwe  dwe  faddr     laddr     daddr     lwd    dwd   rw mrd    gnt     addr      we  wd     done    rdata
        vecs[0] = '{"rr0",  3'b011,0, 0,   0,   16'h1000, 16'h2000, 16'h0000, 8'h00, 8'h00, 0, 8'h11, 3'b001, 16'h1000, 0, 8'h00, 3'b001, 8'h11};
        vecs[1] = '{"rr1",  3'b011,0, 0,   0,   16'h1001, 16'h2001, 16'h0000, 8'h00, 8'h00, 0, 8'h22, 3'b010, 16'h2001, 0, 8'h00, 3'b010, 8'h22};
        vecs[2] = '{"rr2",  3'b011,0, 0,   0,   16'h1002, 16'h2002, 16'h0000, 8'h00, 8'h00, 0, 8'h33, 3'b001, 16'h1002, 0, 8'h00, 3'b001, 8'h33};
        vecs[3] = '{"rr3",  3'b011,0, 0,   0,   16'h1003, 16'h2003, 16'h0000, 8'h00, 8'h00, 0, 8'h44, 3'b010, 16'h2003, 0, 8'h00, 3'b010, 8'h44};
        vecs[4] = '{"fetch",3'b001,0, 0,   0,   16'hC000, 16'h2000, 16'h0000, 8'h00, 8'h00, 0, 8'hA9, 3'b001, 16'hC000, 0, 8'h00, 3'b001, 8'hA9};
        vecs[5] = '{"lsuwr",3'b010,0, 1,   0,   16'h1000, 16'h0200, 16'h0000, 8'h5A, 8'h00, 3, 8'hFF, 3'b010, 16'h0200, 1, 8'h5A, 3'b010, 8'hA9};
        vecs[6] = '{"dmawr",3'b111,0, 0,   1,   16'h1000, 16'h2000, 16'hFE10, 8'h00, 8'hC3, 1, 8'hEE, 3'b100, 16'hFE10, 1, 8'hC3, 3'b100, 8'hA9};
        vecs[7] = '{"dmard",3'b111,1, 0,   0,   16'h1000, 16'h2000, 16'hFE11, 8'h00, 8'h00, 0, 8'h77, 3'b100, 16'hFE11, 0, 8'h00, 3'b100, 8'h77};
        v_unlock = '{"unlk",3'b011,0, 0,   0,   16'h4000, 16'h5000, 16'h0000, 8'h00, 8'h00, 0, 8'h5C, 3'b001, 16'h4000, 0, 8'h00, 3'b001, 8'h5C};

        rstn_i = 1'b0;
        req_i = '0; fetch_addr_i = '0; lsu_addr_i = '0; dma_addr_i = '0;
        lsu_we_i = 1'b0; dma_we_i = 1'b0; lsu_wdata_i = '0; dma_wdata_i = '0;
        dma_lock_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
        #2;
        chk("reset_ctrl", 32'({gnt_o, done_o, busy_o, mem_req_o, mem_we_o}), 32'b0);
        chk("reset_data", 32'({rdata_o, mem_wdata_o, mem_addr_o}), 32'b0);
        tick();
        tick();
        rstn_i = 1'b1;

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i]);

        // DMA lock: right after a DMA beat, fetch/LSU stay blocked while locked.
        dma_lock_i = 1'b1;
        req_i      = 3'b011;
        #1;
        chk("lock_gnt0", 32'(gnt_o), 32'b0);
        tick();
        chk("lock_gnt1", 32'({gnt_o, busy_o}), 32'b0);
        tick();
        chk("lock_gnt2", 32'({gnt_o, busy_o}), 32'b0);
        do_txn(v_unlock);

        // Reset mid-transaction while waiting for the memory response.
        req_i        = 3'b001;
        fetch_addr_i = 16'h3000;
        #1;
        chk("mid_gnt", 32'(gnt_o), 32'b001);
        tick();
        req_i       = '0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        chk("mid_in_wait", 32'({busy_o, mem_req_o}), 32'b10);
        rstn_i = 1'b0;
        req_i  = 3'b011;
        #1;
        chk("mid_rst_ctrl", 32'({gnt_o, done_o, busy_o, mem_req_o, mem_we_o}), 32'b0);
        chk("mid_rst_data", 32'({rdata_o, mem_wdata_o, mem_addr_o}), 32'b0);
        req_i       = '0;
        mem_valid_i = 1'b1;
        mem_rdata_i = 8'hEE;
        tick();
        rstn_i = 1'b1;
        tick();
        mem_valid_i = 1'b0;
        chk("post_rst_done", 32'({done_o, busy_o}), 32'b0);
        chk("post_rst_rdata", 32'(rdata_o), 32'b0);
        req_i = 3'b011;
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the CPU's single memory port between three requesters: instruction fetch (read-only), load/store unit (LSU, read/write) and OAM/sprite DMA (read/write).
- Grants exactly one transaction at a time.
- Drives the memory port with a request/ready handshake on the issue side and a valid strobe on the response side.
- Returns the read byte to the winning requester with a one-hot done pulse.

## Interface
- MEM_ADDR_SIZE, 16, memory address width
- BYTE, 8, data width
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req_i  in  3  request per requester, indexed fetch=0, lsu=1, dma=2; held until granted
- gnt_o  out  3  one-hot grant; combinational, IDLE state only
- fetch_addr_i / lsu_addr_i / dma_addr_i  in  MEM_ADDR_SIZE  request addresses
- lsu_we_i / dma_we_i  in  1  write enables; fetch is always read
- lsu_wdata_i / dma_wdata_i  in  BYTE  write data
- dma_lock_i  in  1  DMA burst lock
- done_o  out  3  one-hot completion pulse, registered
- rdata_o  out  BYTE  read data, valid while done_o is nonzero; holds its last value otherwise
- busy_o  out  1  high when the FSM is not in IDLE
- mem_req_o  out  1  memory request
- mem_ready_i  in  1  memory accepts the request
- mem_we_o  out  1  write enable
- mem_addr_o  out  MEM_ADDR_SIZE  memory address
- mem_wdata_o  out  BYTE  write data
- mem_valid_i  in  1  transaction complete
- mem_rdata_i  in  BYTE  read data

## Operation
- **FSM states:** ARB_IDLE, ARB_ISSUE, ARB_WAIT.
- **ARB_IDLE**
  - If any req_i bit is set, pick a winner and assert its gnt_o bit.
  - Latch the winner's addr, we and wdata into registers, and record the owner ID.
  - Go to ARB_ISSUE.
- **ARB_ISSUE**
  - mem_req_o=1; mem_addr_o, mem_we_o and mem_wdata_o come from the latched registers.
  - Stay until mem_ready_i=1, then go to ARB_WAIT.
- **ARB_WAIT**
  - On mem_valid_i=1, register mem_rdata_i into rdata_o (reads only; unchanged on writes).
  - Set done_o[owner] for one cycle and return to ARB_IDLE.
  - Writes also complete on mem_valid_i.
- **Priority**
  - DMA has highest priority.
  - Fetch and LSU alternate round-robin via a last-winner bit. After reset the bit favours fetch. It updates only when fetch or LSU wins.
- **DMA lock:** while dma_lock_i=1 and the last owner was DMA, fetch and LSU are not granted, even in cycles where req_i[2]=0. This keeps a 256-byte OAM burst atomic.
- **Ignored inputs:**
  - mem_valid_i outside ARB_WAIT.
  - mem_ready_i outside ARB_ISSUE.
- **Outside ARB_ISSUE:** mem_req_o=0 and mem_we_o=0.
- **Reset values (asynchronous reset):**
  - state=ARB_IDLE.
  - gnt_o, done_o, mem_req_o, mem_we_o, busy_o = 0.
  - rdata_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - last-winner bit = LSU, so that fetch wins first.
  - lock owner cleared.
  - Any in-flight response is discarded.

## Timing
- **Zero-wait memory** (mem_ready_i=1, mem_valid_i one cycle after acceptance):
  - req sampled in cycle 0, gnt_o in cycle 0.
  - ARB_ISSUE in cycle 1, ARB_WAIT in cycle 2.
  - done_o in cycle 3.
  - Throughput is one transaction per 3 cycles: arbitration in ARB_IDLE coincides with the done_o cycle of the previous transaction.
- **Memory contract:** mem_valid_i never arrives in the same cycle as mem_ready_i. The arbiter relies on this.
- **Back-pressure:** mem_ready_i low stretches ARB_ISSUE; mem_valid_i late stretches ARB_WAIT. Latched request fields stay stable throughout.
- **Requester contract:** a requester drops req_i or presents its next request in the cycle after gnt_o.
- **Simultaneous requests:** a new req_i asserted during busy_o waits. Grant ordering follows the priority rules at the ARB_IDLE cycle.

## Structure
- **Shared package** (cpu_pkg, alongside the existing MEM_ADDR_SIZE/BYTE):
  - arb_state_t enum: ARB_IDLE/ARB_ISSUE/ARB_WAIT.
  - arb_req_id_t enum: ARB_FETCH=0, ARB_LSU=1, ARB_DMA=2.
  - ARB_NUM_REQ=3.
- **Sub-module:** arb_priority_pick. Combinational; inputs req, last-winner bit and lock qualifier; outputs a one-hot winner.

## Test plan
- **Single fetch:** req_i=001, fetch_addr_i=16'hC000, memory returns 8'hA9 → gnt_o=001 at cycle 0, mem_addr_o=C000 with mem_we_o=0 at cycle 1, done_o=001 and rdata_o=A9 at cycle 3.
- **Round-robin:** req_i=011 held for 4 transactions → grant order fetch, LSU, fetch, LSU.
- **DMA priority and lock:**
  - req_i=111 → DMA wins.
  - With dma_lock_i=1 and req_i=011 between DMA beats, no grant is issued.
  - Lock drops → fetch is granted next.
- **LSU write with back-pressure:** lsu_we_i=1, addr 0200, wdata 5A, mem_ready_i low for 3 cycles → mem_req_o held 4 cycles with stable addr/data; done_o=010; rdata_o unchanged.
- **Reset mid-operation:** rstn_i low while in ARB_WAIT → all outputs 0 immediately; a later mem_valid_i is ignored; the first grant after reset goes to fetch.
